// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//
// Shared constants and helpers for the multi-channel switch debouncer.
//
// Contents:
//   DEFAULT_DELAY        - cycles an input must stay changed before it is
//                          accepted (0.01 s at 100 MHz)
//   DEFAULT_REPEAT_FIRST - cycles held before the first auto-repeat pulse
//   DEFAULT_REPEAT_RATE  - cycles between later auto-repeat pulses
//   cnt_width(x)         - bits needed for a counter that holds 0..x
//
// The auto-repeat constants are used only when DEBOUNCE_AUTOREPEAT_EN is
// defined.
// -----------------------------------------------------------------------------
package debounce_pkg;

    localparam int DEFAULT_DELAY        = 1000000;
    localparam int DEFAULT_REPEAT_FIRST = 50000000;
    localparam int DEFAULT_REPEAT_RATE  = 10000000;

    // Width of a counter that must represent every value 0..x.
    function automatic int cnt_width(input int x);
        return $clog2(x + 1);
    endfunction

endpackage : debounce_pkg

// File: rtl/debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
//
// Debounces one asynchronous switch input. The raw input goes through a
// two-flop synchroniser. A counter then measures how long the synchronised
// value has differed from the accepted (clean) level. Once it has differed
// for DELAY consecutive cycles, the new level is accepted and a one-cycle
// press or release pulse is produced. Both edges are debounced the same way.
//
// Optional feature (macro DEBOUNCE_AUTOREPEAT_EN):
//   While the clean level stays high, repeat_pulse fires REPEAT_FIRST cycles
//   after the press and then every REPEAT_RATE cycles. Without the macro,
//   repeat_pulse is tied low and no repeat counter exists.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous reset, active low
//   noisy         in   raw switch input (asynchronous)
//   clean         out  debounced level
//   press         out  one-cycle pulse on the cycle clean rises
//   release_pulse out  one-cycle pulse on the cycle clean falls
//   repeat_pulse  out  one-cycle auto-repeat pulse while held
// -----------------------------------------------------------------------------
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int DELAY        = DEFAULT_DELAY,
    parameter int REPEAT_FIRST = DEFAULT_REPEAT_FIRST,
    parameter int REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
    input  logic clk,
    input  logic reset,
    input  logic noisy,
    output logic clean,
    output logic press,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int CW = cnt_width(DELAY);

    logic          s1;
    logic          s2;
    logic [CW-1:0] count;
    logic          accept;

    // The synchronised input has disagreed with clean for DELAY cycles,
    // counting this one. The counter is cleared on acceptance, so it never
    // goes past DELAY-1.
    assign accept = (s2 != clean) && (count == CW'(DELAY - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            count         <= '0;
            clean         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            s1            <= noisy;
            s2            <= s1;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            if (s2 == clean) begin
                // Any agreement discards progress: no partial credit
                // carries across a glitch.
                count <= '0;
            end else if (accept) begin
                clean         <= s2;
                count         <= '0;
                press         <= s2;
                release_pulse <= ~s2;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN

    localparam int RMAX = (REPEAT_FIRST > REPEAT_RATE) ? REPEAT_FIRST : REPEAT_RATE;
    localparam int RW   = cnt_width(RMAX);

    logic [RW-1:0] rcnt;
    logic          first_done;
    logic [RW-1:0] rlimit;

    // Before the first repeat the hold period is REPEAT_FIRST. After it the
    // counter restarts from zero and runs at REPEAT_RATE.
    assign rlimit = first_done ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_FIRST - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rcnt         <= '0;
            first_done   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else if (!clean || accept) begin
            // Held in reset while the switch is released. Also cleared on
            // every acceptance. On a press edge this starts the hold period
            // from the press cycle. On a release edge it suppresses any repeat
            // in the release cycle.
            rcnt         <= '0;
            first_done   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else if (rcnt == rlimit) begin
            rcnt         <= '0;
            first_done   <= 1'b1;
            repeat_pulse <= 1'b1;
        end else begin
            rcnt         <= rcnt + 1'b1;
            repeat_pulse <= 1'b0;
        end
    end

`else

    // Feature disabled: repeat_pulse is a constant 0. The repeat parameters
    // are still referenced so both builds share one parameter list. The
    // configuration term is always true for legal settings.
    localparam bit REPEAT_CFG_OK = (REPEAT_FIRST >= 1) && (REPEAT_RATE >= 1);

    assign repeat_pulse = 1'b0 & REPEAT_CFG_OK;

`endif

endmodule : debounce_ch

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//
// Debounces N_CH independent push-button/switch inputs in parallel. Each
// channel has its own synchroniser, debounce counter and edge pulses (see
// debounce_ch). Channels do not interact. Simultaneous events on several
// channels each raise their own pulse in the same cycle.
//
// The per-channel release and auto-repeat pulses are exposed as
// release_pulse and repeat_pulse, because "release" and "repeat" are
// reserved words in SystemVerilog.
//
// Optional feature (macro DEBOUNCE_AUTOREPEAT_EN): enables the per-channel
// auto-repeat pulse. Without it, repeat_pulse is all zeros.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous reset, active low
//   noisy         in   [N_CH] raw switch inputs
//   clean         out  [N_CH] debounced levels
//   press         out  [N_CH] one-cycle pulse when clean rises
//   release_pulse out  [N_CH] one-cycle pulse when clean falls
//   repeat_pulse  out  [N_CH] one-cycle auto-repeat pulse while held
//   any_press     out  registered OR of press, one cycle after the press pulse
// -----------------------------------------------------------------------------
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int DELAY        = DEFAULT_DELAY,
    parameter int REPEAT_FIRST = DEFAULT_REPEAT_FIRST,
    parameter int REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] noisy,
    output logic [N_CH-1:0] clean,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] repeat_pulse,
    output logic            any_press
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .DELAY        (DELAY),
            .REPEAT_FIRST (REPEAT_FIRST),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .noisy         (noisy[i]),
            .clean         (clean[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

    // Registered so that downstream logic sees a flop output. It lags the
    // press pulses by exactly one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press;
        end
    end

endmodule : debounce_multi

// File: tb/tb_debounce_multi.sv
module tb_debounce_multi;

  localparam int N_CH  = 4;
  localparam int DELAY = 4;
  localparam int RF    = 10;
  localparam int RR    = 3;
  localparam int W     = 4 * N_CH + 1;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] noisy;
  logic [N_CH-1:0] clean;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] repeat_pulse;
  logic            any_press;

  always #5 clk = ~clk;

  debounce_multi #(
    .N_CH         (N_CH),
    .DELAY        (DELAY),
    .REPEAT_FIRST (RF),
    .REPEAT_RATE  (RR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .noisy         (noisy),
    .clean         (clean),
    .press         (press),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .any_press     (any_press)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]    exp_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  int              cyc      = 0;
  logic [N_CH-1:0] exp_clean;
  logic [N_CH-1:0] prev_press;
  int              press_cyc[N_CH];

  typedef struct {
    logic [N_CH-1:0] noisy;
    int              hold;
    int              at;     // edge (1-based) where the pulse is due, 0 = none
    logic [N_CH-1:0] ep;
    logic [N_CH-1:0] er;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_clean  = '0;
    prev_press = '0;
    for (int c = 0; c < N_CH; c++) press_cyc[c] = -1;
  endtask

  // One clock edge. The expected outputs after the edge go onto the queue,
  // then they are popped and compared once the DUT has produced them.
  task automatic step(input logic [N_CH-1:0] ep, input logic [N_CH-1:0] er);
    logic [N_CH-1:0] rpt;
    logic            any;
    logic [W-1:0]    e;
    int              d;
    cyc++;
    any        = |prev_press;
    prev_press = ep;
    exp_clean  = exp_clean ^ (ep | er);
    rpt        = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ep[c]) press_cyc[c] = cyc;
      if (er[c]) press_cyc[c] = -1;
      d = cyc - press_cyc[c];
`ifdef DEBOUNCE_AUTOREPEAT_EN
      if (exp_clean[c] && press_cyc[c] >= 0 && d >= RF && ((d - RF) % RR) == 0)
        rpt[c] = 1'b1;
`endif
    end
    exp_q.push_back({exp_clean, ep, er, rpt, any});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("clean",     32'(clean),         32'(e[16:13]));
    check("press",     32'(press),         32'(e[12:9]));
    check("release",   32'(release_pulse), 32'(e[8:5]));
    check("repeat",    32'(repeat_pulse),  32'(e[4:1]));
    check("any_press", 32'(any_press),     32'(e[0]));
  endtask

  // ---------------- driver ----------------
  task automatic run_vec(input logic [N_CH-1:0] nv, input int hold, input int at,
                         input logic [N_CH-1:0] ep, input logic [N_CH-1:0] er);
    noisy = nv;
    for (int k = 1; k <= hold; k++) begin
      if (k == at) step(ep, er);
      else         step('0, '0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_CH-1:0] mask;
    int              len;

    // noisy,  hold, at, press,   release
    vecs[0]  = '{4'b0000, 8, 6, 4'b0000, 4'b1111};
    vecs[1]  = '{4'b0001, 8, 6, 4'b0001, 4'b0000};   // clean press ch0
    vecs[2]  = '{4'b0011, 3, 0, 4'b0000, 4'b0000};   // bounce ch1
    vecs[3]  = '{4'b0001, 2, 0, 4'b0000, 4'b0000};
    vecs[4]  = '{4'b0011, 3, 0, 4'b0000, 4'b0000};
    vecs[5]  = '{4'b0001, 2, 0, 4'b0000, 4'b0000};
    vecs[6]  = '{4'b0011, 8, 6, 4'b0010, 4'b0000};   // final rise ch1
    vecs[7]  = '{4'b0010, 8, 6, 4'b0000, 4'b0001};   // release ch0
    vecs[8]  = '{4'b1010, 8, 6, 4'b1000, 4'b0000};
    vecs[9]  = '{4'b0110, 8, 6, 4'b0100, 4'b1000};   // ch2 up, ch3 down together
    vecs[10] = '{4'b0111, 1, 0, 4'b0000, 4'b0000};   // one-cycle glitch
    vecs[11] = '{4'b0110, 8, 0, 4'b0000, 4'b0000};
    vecs[12] = '{4'b0000, 8, 6, 4'b0000, 4'b0110};
    vecs[13] = '{4'b0001, 36, 6, 4'b0001, 4'b0000};  // long hold
    vecs[14] = '{4'b0000, 8, 6, 4'b0000, 4'b0001};
    vecs[15] = '{4'b1111, 8, 6, 4'b1111, 4'b0000};

    // Reset held with all inputs high: nothing may leave reset state.
    reset = 1'b0;
    noisy = 4'b1111;
    model_reset();
    for (int i = 0; i < 4; i++) step('0, '0);

    // Releasing reset: the held inputs are accepted on edge 6.
    reset = 1'b1;
    run_vec(4'b1111, 8, 6, 4'b1111, 4'b0000);

    for (int i = 0; i < 16; i++)
      run_vec(vecs[i].noisy, vecs[i].hold, vecs[i].at, vecs[i].ep, vecs[i].er);

    // Random short glitches (< DELAY cycles) must never be accepted.
    for (int i = 0; i < 6; i++) begin
      mask = 4'($urandom_range(1, 15));
      len  = $urandom_range(1, DELAY - 1);
      run_vec(exp_clean ^ mask, len, 0, '0, '0);
      run_vec(exp_clean, 6, 0, '0, '0);
    end

    // Reset asserted in the middle of a release count clears everything at once.
    run_vec(4'b0000, 3, 0, '0, '0);
    #2;
    reset = 1'b0;
    #1;
    check("async_clean",   32'(clean),         32'(0));
    check("async_press",   32'(press),         32'(0));
    check("async_release", 32'(release_pulse), 32'(0));
    check("async_any",     32'(any_press),     32'(0));
    model_reset();
    noisy = 4'b1111;
    step('0, '0);
    step('0, '0);
    reset = 1'b1;
    run_vec(4'b1111, 8, 6, 4'b1111, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
